// File: rtl/nn_pkg.sv
// Shared sizing defaults, error-bit indices and the result saturation helper
// for the neuron-layer datapath.
package nn_pkg;

   localparam int N_DEF = 8;
   localparam int D_DEF = 4;
   localparam int Q_DEF = 3;

   localparam int ERR_PROTO = 0;
   localparam int ERR_COUNT = 1;
   localparam int ERR_OVF   = 2;
   localparam int ERR_W     = 3;

   function automatic int acc_w(input int n, input int d);
      return 2 * n + $clog2(d);
   endfunction

   // Clamp a sign-extended accumulator value into the 2n-bit signed range.
   function automatic logic signed [63:0] sat2n(input logic signed [63:0] v, input int n);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (2 * n - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (2 * n - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/mac_stage.sv
// Operand registers with freshness tracking, one-stage signed multiplier and
// accumulator with forwarding of the pending product.
module mac_stage
   import nn_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int D     = D_DEF,
   parameter int ACC_W = acc_w(N, D),
   parameter int TW    = $clog2(D + 1) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st,
   input  logic             write_x,
   input  logic             write_w,
   input  logic [N-1:0]     x_in,
   input  logic [N-1:0]     w_in,
   input  logic             acc_write,
   input  logic             clear_acc,
   output logic [ACC_W-1:0] acc_next,
   output logic [TW-1:0]    term_cnt,
   output logic             busy,
   output logic             proto_hit
);

   logic [N-1:0]     x_reg;
   logic [N-1:0]     w_reg;
   logic             x_fresh;
   logic             w_fresh;
   logic [2*N-1:0]   x_ext;
   logic [2*N-1:0]   w_ext;
   logic [2*N-1:0]   prod;
   logic [2*N-1:0]   prod_reg;
   logic             prod_valid;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] prod_acc;
   logic             fire;

   assign fire      = acc_write && x_fresh && w_fresh;
   assign proto_hit = acc_write && !(x_fresh && w_fresh) && !st;
   assign busy      = prod_valid;

   // Low 2N bits of the product of sign-extended operands equal the signed product.
   assign x_ext = {{N{x_reg[N-1]}}, x_reg};
   assign w_ext = {{N{w_reg[N-1]}}, w_reg};
   assign prod  = x_ext * w_ext;

   assign prod_acc = {{(ACC_W-2*N){prod_reg[2*N-1]}}, prod_reg};
   assign acc_next = acc + (prod_valid ? prod_acc : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg      <= '0;
         w_reg      <= '0;
         x_fresh    <= 1'b0;
         w_fresh    <= 1'b0;
         prod_reg   <= '0;
         prod_valid <= 1'b0;
         acc        <= '0;
         term_cnt   <= '0;
      end else if (st) begin
         x_fresh    <= 1'b0;
         w_fresh    <= 1'b0;
         prod_valid <= 1'b0;
         acc        <= '0;
         term_cnt   <= '0;
      end else begin
         // A coincident operand write wins over consumption: the new value is fresh.
         if (write_x) begin
            x_reg   <= x_in;
            x_fresh <= 1'b1;
         end else if (fire) begin
            x_fresh <= 1'b0;
         end
         if (write_w) begin
            w_reg   <= w_in;
            w_fresh <= 1'b1;
         end else if (fire) begin
            w_fresh <= 1'b0;
         end
         if (fire) prod_reg <= prod;
         if (clear_acc) begin
            acc        <= '0;
            term_cnt   <= '0;
            prod_valid <= 1'b0;
         end else begin
            acc        <= acc_next;
            prod_valid <= fire;
            if (fire && term_cnt != '1) term_cnt <= term_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_neuron_datapath.sv
// Neuron-layer datapath: MAC stage plus saturated result file, run pointer,
// completion flag and sticky protocol error flags.
module mac_neuron_datapath
   import nn_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int D     = D_DEF,
   parameter int Q     = Q_DEF,
   parameter int ACC_W = acc_w(N, D)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   st,
   input  logic                   write_x,
   input  logic                   write_w,
   input  logic [N-1:0]           x_in,
   input  logic [N-1:0]           w_in,
   input  logic                   acc_write,
   input  logic                   res_write,
   input  logic                   clear_acc,
   input  logic                   done,
   input  logic [$clog2(Q)-1:0]   rd_addr,
   output logic [2*N-1:0]         rd_data,
   output logic [$clog2(Q+1)-1:0] res_count,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   proto_err,
   output logic                   count_err,
   output logic                   ovf_err
);

   localparam int PW = $clog2(Q + 1);
   localparam int AW = $clog2(Q);
   localparam int TW = $clog2(D + 1) + 1;

   logic [ACC_W-1:0] acc_next;
   logic [TW-1:0]    term_cnt;
   logic             proto_hit;
   logic [2*N-1:0]   wdata;
   logic [2*N-1:0]   mem [Q];
   logic [PW-1:0]    res_ptr;
   logic             full;
   logic [ERR_W-1:0] err;

   mac_stage #(
      .N     (N),
      .D     (D),
      .ACC_W (ACC_W),
      .TW    (TW)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .st        (st),
      .write_x   (write_x),
      .write_w   (write_w),
      .x_in      (x_in),
      .w_in      (w_in),
      .acc_write (acc_write),
      .clear_acc (clear_acc),
      .acc_next  (acc_next),
      .term_cnt  (term_cnt),
      .busy      (busy),
      .proto_hit (proto_hit)
   );

   assign wdata = (2*N)'(sat2n({{(64-ACC_W){acc_next[ACC_W-1]}}, acc_next}, N));
   assign full  = (res_ptr == PW'(Q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_ptr   <= '0;
         err       <= '0;
         out_valid <= 1'b0;
         for (int unsigned i = 0; i < Q; i++) mem[i] <= '0;
      end else if (st) begin
         res_ptr   <= '0;
         err       <= '0;
         out_valid <= 1'b0;
      end else begin
         if (res_write) begin
            if (!full) begin
               for (int unsigned i = 0; i < Q; i++)
                  if (res_ptr == PW'(i)) mem[i] <= wdata;
               res_ptr <= res_ptr + 1'b1;
            end else begin
               err[ERR_OVF] <= 1'b1;
            end
            if (term_cnt != TW'(D)) err[ERR_COUNT] <= 1'b1;
         end
         if (proto_hit) err[ERR_PROTO] <= 1'b1;
         if (done) out_valid <= 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < Q; i++)
         if (rd_addr == AW'(i)) rd_data = mem[i];
   end

   assign res_count = res_ptr;
   assign proto_err = err[ERR_PROTO];
   assign count_err = err[ERR_COUNT];
   assign ovf_err   = err[ERR_OVF];

endmodule

// File: tb/tb_mac_neuron_datapath.sv
// Self-checking bench for mac_neuron_datapath: directed scenarios plus a
// randomized strobe mix compared against a cycle-level behavioural model.
module tb_mac_neuron_datapath;

   localparam int N = 8;
   localparam int D = 4;
   localparam int Q = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st = 1'b0, write_x = 1'b0, write_w = 1'b0, acc_write = 1'b0;
   logic        res_write = 1'b0, clear_acc = 1'b0, done = 1'b0;
   logic [7:0]  x_in = '0, w_in = '0;
   logic [1:0]  rd_addr = '0;
   logic [15:0] rd_data;
   logic [1:0]  res_count;
   logic        out_valid, busy, proto_err, count_err, ovf_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mac_neuron_datapath #(.N(N), .D(D), .Q(Q)) dut (
      .clk       (clk),
      .rst       (rst),
      .st        (st),
      .write_x   (write_x),
      .write_w   (write_w),
      .x_in      (x_in),
      .w_in      (w_in),
      .acc_write (acc_write),
      .res_write (res_write),
      .clear_acc (clear_acc),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .res_count (res_count),
      .out_valid (out_valid),
      .busy      (busy),
      .proto_err (proto_err),
      .count_err (count_err),
      .ovf_err   (ovf_err)
   );

   // Behavioural model: operands, freshness, pending product, accumulator, results.
   int     mx, mw, mterms, mptr;
   bit     mxf, mwf, mpv, mpe, mce, moe, mov;
   longint mprod, macc;
   longint mmem [Q];

   function automatic longint sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint model_rd(input int a);
      return (a < Q) ? mmem[a] : 0;
   endfunction

   task automatic model_reset();
      mx = 0; mw = 0; mterms = 0; mptr = 0;
      mxf = 0; mwf = 0; mpv = 0; mpe = 0; mce = 0; moe = 0; mov = 0;
      mprod = 0; macc = 0;
      for (int i = 0; i < Q; i++) mmem[i] = 0;
   endtask

   task automatic model_step();
      longint nxt, p;
      bit fire;
      if (st) begin
         macc = 0; mterms = 0; mpv = 0; mxf = 0; mwf = 0;
         mptr = 0; mov = 0; mpe = 0; mce = 0; moe = 0;
         return;
      end
      nxt = macc + (mpv ? mprod : 0);
      if (res_write) begin
         if (mptr < Q) begin
            mmem[mptr] = sat16(nxt);
            mptr++;
         end else moe = 1;
         if (mterms != D) mce = 1;
      end
      fire = acc_write && mxf && mwf;
      if (acc_write && !fire) mpe = 1;
      p = longint'(mx) * longint'(mw);
      if (clear_acc) begin
         macc = 0; mterms = 0; mpv = 0;
      end else begin
         macc = nxt;
         mpv  = fire;
         if (fire) begin mprod = p; mterms++; end
      end
      if (fire) begin mxf = 0; mwf = 0; end
      if (write_x) begin mx = int'($signed(x_in)); mxf = 1; end
      if (write_w) begin mw = int'($signed(w_in)); mwf = 1; end
      if (done) mov = 1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      st = 0; write_x = 0; write_w = 0; acc_write = 0;
      res_write = 0; clear_acc = 0; done = 0;
   endtask

   task automatic start();
      idle(); st = 1; tick(); idle();
   endtask

   task automatic term(input int x, input int w);
      write_x = 1; write_w = 1; x_in = 8'(x); w_in = 8'(w);
      tick(); idle();
      acc_write = 1;
      tick(); idle();
   endtask

   task automatic test_reset();
      model_reset();
      #2;
      n_tests++;
      if ({res_count, out_valid, busy, proto_err, count_err, ovf_err} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 0", {res_count, out_valid, busy, proto_err, count_err, ovf_err});
      end
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a); #0.1;
         n_tests++;
         if (rd_data !== 16'd0) begin
            n_fail++; $display("FAIL reset_rd_data[%0d]: got %0d expected 0", a, rd_data);
         end
      end
      rst = 0;
   endtask

   task automatic test_dot();
      start();
      for (int i = 1; i <= 4; i++) term(i, i + 4);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL dot_busy: got %b expected 1", busy); end
      res_write = 1; tick(); idle();
      rd_addr = 0; #1;
      n_tests++;
      if (rd_data !== 16'd70) begin n_fail++; $display("FAIL dot_value: got %0d expected 70", $signed(rd_data)); end
      n_tests++;
      if (res_count !== 2'd1) begin n_fail++; $display("FAIL dot_count: got %0d expected 1", res_count); end
      n_tests++;
      if ({proto_err, count_err, ovf_err} !== 3'b000) begin
         n_fail++; $display("FAIL dot_errors: got %b expected 000", {proto_err, count_err, ovf_err});
      end
   endtask

   task automatic test_saturation();
      start();
      for (int i = 0; i < 4; i++) term(-128, -128);
      res_write = 1; clear_acc = 1; tick(); idle();
      for (int i = 0; i < 4; i++) term(-128, 127);
      res_write = 1; tick(); idle();
      rd_addr = 0; #1;
      n_tests++;
      if (rd_data !== 16'h7fff) begin n_fail++; $display("FAIL sat_pos: got %0d expected 32767", $signed(rd_data)); end
      rd_addr = 1; #1;
      n_tests++;
      if (rd_data !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %0d expected -32768", $signed(rd_data)); end
      n_tests++;
      if ({res_count, count_err, ovf_err} !== 4'b1000) begin
         n_fail++; $display("FAIL sat_status: got %b expected 1000", {res_count, count_err, ovf_err});
      end
   endtask

   task automatic test_proto();
      start();
      write_x = 1; x_in = 8'd3; tick(); idle();
      acc_write = 1; tick(); idle();
      n_tests++;
      if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_flag: got %b expected 1", proto_err); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL proto_no_product: got busy %b expected 0", busy); end
      write_w = 1; w_in = 8'd4; tick(); idle();
      acc_write = 1; tick(); idle();
      for (int i = 0; i < 3; i++) term(1, 1);
      res_write = 1; tick(); idle();
      rd_addr = 0; #1;
      n_tests++;
      if (rd_data !== 16'd15) begin n_fail++; $display("FAIL proto_acc_kept: got %0d expected 15", $signed(rd_data)); end
      n_tests++;
      if (count_err !== 1'b0) begin n_fail++; $display("FAIL proto_term_cnt: got count_err %b expected 0", count_err); end
   endtask

   task automatic test_overflow();
      longint exp_v [Q];
      start();
      for (int r = 0; r < Q; r++) begin
         longint s;
         s = 0;
         for (int t = 0; t < D; t++) begin
            int x, w;
            x = int'($urandom_range(255)) - 128;
            w = int'($urandom_range(255)) - 128;
            s += longint'(x) * longint'(w);
            term(x, w);
         end
         exp_v[r] = sat16(s);
         res_write = 1; clear_acc = 1; tick(); idle();
      end
      n_tests++;
      if ({res_count, count_err, ovf_err} !== 4'b1100) begin
         n_fail++; $display("FAIL ovf_full_status: got %b expected 1100", {res_count, count_err, ovf_err});
      end
      res_write = 1; tick(); idle();
      n_tests++;
      if ({res_count, ovf_err, count_err} !== 4'b1111) begin
         n_fail++; $display("FAIL ovf_flag: got %b expected 1111", {res_count, ovf_err, count_err});
      end
      for (int a = 0; a < Q; a++) begin
         rd_addr = 2'(a); #1;
         n_tests++;
         if (rd_data !== 16'(exp_v[a])) begin
            n_fail++; $display("FAIL ovf_mem[%0d]: got %0d expected %0d", a, $signed(rd_data), exp_v[a]);
         end
      end
      done = 1; tick(); idle();
      res_write = 1; tick(); idle();
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL done_valid: got %b expected 1", out_valid); end
      st = 1; tick(); idle();
      n_tests++;
      if ({out_valid, res_count, proto_err, count_err, ovf_err} !== 6'd0) begin
         n_fail++; $display("FAIL st_clear: got %b expected 0", {out_valid, res_count, proto_err, count_err, ovf_err});
      end
      rd_addr = 2; #1;
      n_tests++;
      if (rd_data !== 16'(exp_v[2])) begin
         n_fail++; $display("FAIL st_retain: got %0d expected %0d", $signed(rd_data), exp_v[2]);
      end
   endtask

   task automatic test_clear_priority();
      start();
      term(1, 5); term(2, 6);
      write_x = 1; write_w = 1; x_in = 8'd3; w_in = 8'd7; tick(); idle();
      acc_write = 1; clear_acc = 1; tick(); idle();
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_discard: got busy %b expected 0", busy); end
      n_tests++;
      if (proto_err !== 1'b0) begin n_fail++; $display("FAIL clr_no_err: got %b expected 0", proto_err); end
      for (int i = 1; i <= 4; i++) term(i, i + 4);
      res_write = 1; clear_acc = 1; tick(); idle();
      res_write = 1; tick(); idle();
      rd_addr = 0; #1;
      n_tests++;
      if (rd_data !== 16'd70) begin n_fail++; $display("FAIL clr_entry: got %0d expected 70", $signed(rd_data)); end
      rd_addr = 1; #1;
      n_tests++;
      if (rd_data !== 16'd0) begin n_fail++; $display("FAIL clr_acc_zero: got %0d expected 0", $signed(rd_data)); end
      n_tests++;
      if (count_err !== 1'b1) begin n_fail++; $display("FAIL clr_term_cnt: got count_err %b expected 1", count_err); end
   endtask

   task automatic test_async_reset();
      write_x = 1; write_w = 1; x_in = 8'd5; w_in = 8'd6; done = 1; tick(); idle();
      acc_write = 1; tick(); idle();
      rd_addr = 0; #1;
      n_tests++;
      if ({busy, out_valid, rd_data} !== {1'b1, 1'b1, 16'd70}) begin
         n_fail++; $display("FAIL arst_pre: got busy %b valid %b data %0d expected 1 1 70", busy, out_valid, rd_data);
      end
      rst = 1; #1;
      n_tests++;
      if ({busy, out_valid, res_count, proto_err, count_err, ovf_err, rd_data} !== 23'd0) begin
         n_fail++; $display("FAIL arst_outputs: got busy %b valid %b cnt %0d err %b data %0d expected all 0",
                            busy, out_valid, res_count, {proto_err, count_err, ovf_err}, rd_data);
      end
      #1 rst = 0;
      model_reset();
      tick();
   endtask

   task automatic test_random();
      start();
      for (int c = 0; c < 400; c++) begin
         st        = ($urandom_range(99) < 2);
         write_x   = ($urandom_range(99) < 40);
         write_w   = ($urandom_range(99) < 40);
         acc_write = ($urandom_range(99) < 35);
         res_write = ($urandom_range(99) < 15);
         clear_acc = ($urandom_range(99) < 10) || (mterms >= 6);
         done      = ($urandom_range(99) < 3);
         x_in      = 8'($urandom);
         w_in      = 8'($urandom);
         rd_addr   = 2'($urandom_range(3));
         tick();
         n_tests++;
         if ({res_count, out_valid, busy} !== {2'(mptr), mov, mpv}) begin
            n_fail++; $display("FAIL rand_status @%0d: got cnt %0d valid %b busy %b expected %0d %b %b",
                               c, res_count, out_valid, busy, mptr, mov, mpv);
         end
         n_tests++;
         if ({proto_err, count_err, ovf_err} !== {mpe, mce, moe}) begin
            n_fail++; $display("FAIL rand_errors @%0d: got %b expected %b", c, {proto_err, count_err, ovf_err}, {mpe, mce, moe});
         end
         n_tests++;
         if (rd_data !== 16'(model_rd(int'(rd_addr)))) begin
            n_fail++; $display("FAIL rand_rd_data @%0d addr %0d: got %0d expected %0d",
                               c, rd_addr, $signed(rd_data), model_rd(int'(rd_addr)));
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_dot();
      test_saturation();
      test_proto();
      test_overflow();
      test_clear_priority();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_neuron_datapath.md
Name: mac_neuron_datapath

Overview:
Datapath responder for the neuron-layer controller. It consumes the controller's strobes (write_x, write_w, acc_write, res_write, clear_acc, done) and operand buses. It performs the signed multiply-accumulate over D terms per neuron, stores Q saturated neuron results in a result register file, and exposes them on a read port. It also flags protocol violations by the initiator.

Parameters:
N, 8, operand width (signed two's complement)
D, 4, terms per neuron
Q, 3, neurons per run (result entries)
ACC_W, 2*N+$clog2(D), accumulator width (no internal overflow possible)

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
st  in  1  run start pulse; clears run state
write_x  in  1  load x_in into operand reg
write_w  in  1  load w_in into operand reg
x_in  in  N  signed input datum
w_in  in  N  signed weight
acc_write  in  1  accumulate current operands
res_write  in  1  commit accumulator to result file
clear_acc  in  1  zero accumulator for next neuron
done  in  1  run complete
rd_addr  in  $clog2(Q)  result read index
rd_data  out  2*N  result entry (combinational read)
res_count  out  $clog2(Q+1)  results stored this run
out_valid  out  1  results final (set by done)
busy  out  1  product pending in pipeline
proto_err  out  1  sticky: acc_write without both operands fresh
count_err  out  1  sticky: res_write with term_cnt != D
ovf_err  out  1  sticky: res_write when file full

Behaviour:
- Reset (async): x_reg, w_reg, fresh flags, prod_reg, prod_valid, acc, term_cnt, res_ptr, result file, and all outputs go to 0.
- write_x / write_w: independent. Each loads its register and sets x_fresh / w_fresh. Both may assert in the same cycle.
- acc_write, cycle k:
  - If x_fresh && w_fresh: prod_reg <= signed x_reg*w_reg (2N bits); prod_valid <= 1; both fresh flags cleared; term_cnt++.
  - Otherwise: no product, proto_err <= 1.
  - If write_x/write_w coincide with acc_write, the old register values are used. New values load and set fresh.
- Accumulation, cycle k+1: acc <= acc + sign_ext(prod_reg); prod_valid <= 0. busy = prod_valid.
- Forwarding: acc_next = acc + (prod_valid ? sign_ext(prod_reg) : 0). res_write uses acc_next, so res_write one cycle after the last acc_write captures all D terms.
- res_write:
  - If res_ptr < Q: mem[res_ptr] <= sat(acc_next) to 2N signed range [-2^(2N-1), 2^(2N-1)-1]; res_ptr++.
  - Else: no write, ovf_err <= 1.
  - If term_cnt != D: count_err <= 1; entry is still written.
- clear_acc: acc, term_cnt, prod_valid <= 0; fresh flags untouched.
- Same-cycle priorities:
  - clear_acc with acc_write: clear wins. The new product is discarded, term_cnt ends at 0, fresh flags are still consumed, no error.
  - clear_acc with res_write: result is stored from acc_next first, then cleared.
  - st has top priority over all strobes: clears acc, term_cnt, prod_valid, fresh flags, res_ptr, out_valid and all sticky errors. Result file contents are retained but invalidated by res_count=0.
- done: out_valid <= 1 and held until st or rst. Strobes after done still act; out_valid stays 1.
- res_count = res_ptr, saturates at Q; no wrap-around.
- rd_data = mem[rd_addr]. rd_addr >= Q returns 0.
- rst mid-operation: immediate return to reset values, including the pending product.
- Latency: operand to accumulator 2 cycles; acc_next to result file 1 cycle.

Decomposition:
- Shared package nn_pkg: N/D/Q defaults, ACC_W function, sat2n function (ACC_W to 2N signed saturation), error-bit index constants.
- One sub-module: mac_stage (operand registers, fresh flags, multiplier, prod_reg, accumulator with forwarding and clear). Top holds result file, pointer, flags.

Test Plan:
- st; D=4 terms x={1,2,3,4}, w={5,6,7,8}, each write_x+write_w then acc_write; res_write next cycle -> mem[0]=70, res_count=1, no errors.
- Four terms x=-128, w=-128 -> acc=65536 -> mem[0]=32767 (saturated). Repeat with w=127 -> -65024 -> mem[1]=-32768.
- acc_write with only write_x since the last acc -> proto_err=1, term_cnt unchanged, acc unchanged.
- Q=3 full runs, then a 4th res_write -> ovf_err=1, mem contents unchanged, res_count=3. Then done -> out_valid=1. Then st -> out_valid=0, res_count=0, errors cleared.
- acc_write+clear_acc same cycle after 2 terms (acc=17) -> acc=0, term_cnt=0. res_write+clear_acc same cycle with acc=70 -> entry=70, acc=0.
- Assert rst with prod_valid=1 -> busy=0, acc=0, all outputs 0 asynchronously, before the next clk edge.
